// File: rtl/z_result_stage.sv
// z_result_stage: 2-entry result FIFO between the rotate/shift unit and the Z register; ports clk, clr (async active-high), Rz_in/in_valid/in_ready, Zlow/out_valid/out_ready, zero_flag, neg_flag, accept_cnt; define Z_FLAGS_EN to store per-entry zero/negative flags
module z_result_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] Rz_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] Zlow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        zero_flag,
  output logic        neg_flag,
  output logic [15:0] accept_cnt
);
`ifdef Z_FLAGS_EN
  localparam int W = 34;
`else
  localparam int W = 32;
`endif
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t      state_q, state_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] din;
  logic [15:0]  cnt_q, cnt_d;
  logic         push, pop;
  assign in_ready   = state_q != FULL;
  assign out_valid  = state_q != EMPTY;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign accept_cnt = cnt_q;
  // entry 0 is always the head; vacated entries are zeroed so Zlow reads 0 when empty
  assign Zlow       = mem_q[0][31:0];
`ifdef Z_FLAGS_EN
  assign din       = {Rz_in == 32'h0, Rz_in[31], Rz_in};
  assign zero_flag = mem_q[0][33];
  assign neg_flag  = mem_q[0][32];
`else
  assign din       = Rz_in;
  assign zero_flag = 1'b0;
  assign neg_flag  = 1'b0;
`endif
  always_comb begin
    cnt_d    = push ? cnt_q + 16'd1 : cnt_q;
    state_d  = state_q == EMPTY ? (push ? ONE : EMPTY) :
               state_q == ONE   ? (push && !pop ? FULL : (!push && pop ? EMPTY : ONE)) :
               (pop ? ONE : FULL);
    mem_d[0] = pop ? (state_q == FULL ? mem_q[1] : (push ? din : '0)) :
               (push && state_q == EMPTY ? din : mem_q[0]);
    mem_d[1] = push && !pop && state_q == ONE ? din :
               (pop && state_q == FULL ? '0 : mem_q[1]);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      mem_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
    end
  end
endmodule

// File: tb/tb_z_result_stage.sv
// tb_z_result_stage: directed self-checking bench for z_result_stage
module tb_z_result_stage;
`ifdef Z_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] Rz_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Zlow;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        zero_flag;
  logic        neg_flag;
  logic [15:0] accept_cnt;
  int checks = 0;
  int errors = 0;
  z_result_stage dut (
    .clk(clk), .clr(clr), .Rz_in(Rz_in), .in_valid(in_valid), .in_ready(in_ready),
    .Zlow(Zlow), .out_valid(out_valid), .out_ready(out_ready),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .accept_cnt(accept_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_zlow", Zlow, 32'h0);
    chk("rst_cnt", 32'(accept_cnt), 32'd0);
    chk("rst_flags", {30'd0, zero_flag, neg_flag}, 32'd0);
    step();
    clr = 1'b0;
    Rz_in = 32'h8000_0001; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_zlow", Zlow, 32'h8000_0001);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_neg", 32'(neg_flag), 32'(FL));
    chk("single_zero", 32'(zero_flag), 32'd0);
    step();
    chk("single_drain", 32'(out_valid), 32'd0);
    chk("single_empty_zlow", Zlow, 32'h0);
    out_ready = 1'b0; in_valid = 1'b1; Rz_in = 32'hA;
    step();
    Rz_in = 32'hB;
    step();
    chk("bp_full_ready", 32'(in_ready), 32'd0);
    Rz_in = 32'hC;
    step();
    in_valid = 1'b0;
    chk("bp_cnt", 32'(accept_cnt), 32'd3);
    chk("bp_hold_zlow", Zlow, 32'hA);
    out_ready = 1'b1;
    step();
    chk("bp_second", Zlow, 32'hB);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_ready_again", 32'(in_ready), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; Rz_in = 32'h1;
    step();
    chk("sim_pre", Zlow, 32'h1);
    Rz_in = 32'h0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sim_zlow", Zlow, 32'h0);
    chk("sim_valid", 32'(out_valid), 32'd1);
    chk("sim_ready", 32'(in_ready), 32'd1);
    chk("sim_zero", 32'(zero_flag), 32'(FL));
    chk("sim_neg", 32'(neg_flag), 32'd0);
    chk("sim_cnt", 32'(accept_cnt), 32'd5);
    step();
    chk("sim_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; Rz_in = 32'h5;
    step();
    Rz_in = 32'h6;
    step();
    in_valid = 1'b0;
    chk("mid_full", 32'(in_ready), 32'd0);
    #2 clr = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_zlow", Zlow, 32'h0);
    chk("mid_cnt", 32'(accept_cnt), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd1);
    #1 clr = 1'b0;
    in_valid = 1'b1; Rz_in = 32'h7;
    step();
    in_valid = 1'b0;
    chk("post_rst_zlow", Zlow, 32'h7);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_cnt", 32'(accept_cnt), 32'd1);
    clr = 1'b1;
    #1 clr = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      Rz_in = 32'(i);
      step();
      if (i == 2) chk("stream_order", Zlow, 32'd2);
    end
    chk("wrap_pre", 32'(accept_cnt), 32'hFFFF);
    chk("wrap_last", Zlow, 32'd65535);
    Rz_in = 32'h0;
    step();
    in_valid = 1'b0;
    chk("wrap_cnt", 32'(accept_cnt), 32'h0);
    chk("wrap_zero_flag", 32'(zero_flag), 32'(FL));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/z_result_stage.md
Z_RESULT_STAGE -- requirements
Module: z_result_stage

Interface
REQ-001 Parameter DEPTH, default 2, is the number of buffered result entries and is fixed at 2 in this revision.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 Rz_in  input  32  result word from the rotate/shift unit output.
REQ-005 in_valid  input  1  Rz_in holds a result to capture this cycle.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 Zlow  output  32  head-of-buffer result word driven toward the Z register / bus.
REQ-008 out_valid  output  1  Zlow is valid.
REQ-009 out_ready  input  1  consumer takes Zlow this cycle.
REQ-010 zero_flag  output  1  head result equals 0 (Z_FLAGS_EN only).
REQ-011 neg_flag  output  1  head result bit 31 (Z_FLAGS_EN only).
REQ-012 accept_cnt  output  16  running count of accepted results.

Function
REQ-013 Push occurs when in_valid and in_ready are both 1 on a rising edge; pop occurs when out_valid and out_ready are both 1.
REQ-014 The block SHALL be a 2-entry FIFO with states EMPTY, ONE and FULL, held in a 2-bit occupancy register.
REQ-015 The transitions SHALL be: EMPTY goes to ONE on push; ONE goes to FULL on push without pop, to EMPTY on pop without push, and stays ONE on push with pop; FULL goes to ONE on pop.
REQ-016 in_ready SHALL be 1 when the state is not FULL; it is derived from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 when the state is not EMPTY; Zlow SHALL be the oldest entry and remain stable while out_valid=1 and out_ready=0.
REQ-018 Latency: a word pushed into EMPTY SHALL appear on Zlow with out_valid=1 in the next cycle.
REQ-019 Simultaneous push and pop in ONE: the old head leaves, the pushed word becomes head next cycle, and no word is lost or duplicated.
REQ-020 Push attempts while FULL SHALL be ignored, with no state or count change; pop attempts while EMPTY SHALL be ignored.
REQ-021 Words SHALL be delivered in push order; the 32-bit data is passed unmodified.
REQ-022 accept_cnt SHALL increment by 1 on each push and wrap from 16'hFFFF to 16'h0000.
REQ-023 Zlow SHALL be 32'h0 whenever the state is EMPTY.

Reset
REQ-024 clr=1 SHALL immediately force: state EMPTY, out_valid 0, in_ready 1, Zlow 32'h0, zero_flag 0, neg_flag 0, accept_cnt 0; both storage entries are cleared to 0.
REQ-025 clr asserted mid-transfer SHALL discard all buffered words; the first push after clr deasserts follows REQ-018.

Configuration
REQ-026 With macro Z_FLAGS_EN defined, each entry SHALL store zero and negative flags computed at push time; zero_flag and neg_flag SHALL follow the head entry.
REQ-027 Without Z_FLAGS_EN, zero_flag and neg_flag SHALL be constant 0 and no flag storage is built.

Verification
REQ-028 Single word: push 32'h8000_0001 into EMPTY with out_ready=1 -> next cycle Zlow=32'h8000_0001, out_valid=1, neg_flag=1 (flags on); following cycle out_valid=0.
REQ-029 Backpressure: out_ready=0; push 32'hA, 32'hB, 32'hC on consecutive cycles -> A and B accepted, in_ready=0 after the second push, C ignored, accept_cnt=2; then out_ready=1 -> Zlow shows A then B.
REQ-030 Simultaneous event: state ONE holding 32'h1; push 32'h0 with out_ready=1 -> state stays ONE, Zlow=32'h0, zero_flag=1.
REQ-031 Reset mid-operation: state FULL, assert clr between clock edges -> out_valid=0, Zlow=0, accept_cnt=0 without waiting for a clock edge.
REQ-032 Counter wrap: preload by 65535 pushes, push one more -> accept_cnt=16'h0000.
REQ-033 Build without Z_FLAGS_EN: push 32'h0 -> zero_flag=0 and neg_flag=0 at all times.
